// File: rtl/uart_bus_master_pkg.sv
// Shared types and constants for the UART-to-bus bridge.
// Covers protocol states, status codes and command byte fields.
package uart_bus_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_BUS,
        S_RSEND,
        S_STATUS
    } state_t;

    localparam logic [7:0] STATUS_OK      = 8'h06;
    localparam logic [7:0] STATUS_TIMEOUT = 8'h15;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_BEATS_MSB = 6;
    localparam int CMD_BEATS_LSB = 0;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop synchroniser.
// valid pulses for one cycle per byte that has a good stop bit.
module uart_rx #(
    parameter int TICK = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t   state;
    logic [1:0]  sync;
    logic [31:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shift;
    logic        rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            state <= R_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            sync  <= {sync[0], rx};
            valid <= 1'b0;
            case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= R_START;
                end
                // Re-check the line half a bit in, to reject glitches.
                R_START: begin
                    if (cnt == 32'(TICK / 2 - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == 32'(TICK - 1)) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (idx == 3'd7) state <= R_STOP;
                        else             idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == 32'(TICK - 1)) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        if (rx_s) begin
                            data  <= shift;
                            valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; ready is high whenever a new byte may be started.
// The line idles high and is forced high by reset.
module uart_tx #(
    parameter int TICK = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    logic        active;
    logic [8:0]  shift;
    logic [3:0]  nbit;
    logic [31:0] cnt;

    assign ready = !active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            shift  <= '0;
            nbit   <= '0;
            cnt    <= '0;
            tx     <= 1'b1;
        end else if (!active) begin
            if (start) begin
                active <= 1'b1;
                tx     <= 1'b0;
                shift  <= {1'b1, data};
                nbit   <= '0;
                cnt    <= '0;
            end
        end else if (cnt == 32'(TICK - 1)) begin
            cnt <= '0;
            // nbit 9 means the stop bit has just been held for a full period.
            if (nbit == 4'd9) begin
                active <= 1'b0;
            end else begin
                tx    <= shift[0];
                shift <= {1'b0, shift[8:1]};
                nbit  <= nbit + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART-driven bus master: decodes read/write frames from the serial line,
// runs single-beat bus cycles with ack timeout, and answers with data + status.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int BAUDRATE    = 115200,
    parameter int SYS_FREQ    = 25000000,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 255,
    parameter int RX_TIMEOUT  = 4 * 10 * SYS_FREQ / BAUDRATE
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    input  logic                  i_ack,
    output logic                  o_we,
    output logic                  o_cs,
    input  logic                  i_uart_rx,
    output logic                  o_uart_tx,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam int TICK = SYS_FREQ / BAUDRATE;
    localparam int AB   = ADDR_WIDTH / 8;
    localparam int DB   = DATA_WIDTH / 8;

    state_t                state;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  tx_start;
    logic [7:0]            tx_data;
    logic                  tx_ready;
    logic                  is_write;
    logic                  timed_out;
    logic [6:0]            beats_left;
    logic [1:0]            byte_cnt;
    logic [31:0]           ack_cnt;
    logic [31:0]           idle_cnt;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rx_expired;
    logic                  ack_expired;
    logic                  beat_end;
    logic                  tx_free;

    uart_rx #(.TICK(TICK)) u_rx (
        .clk   (i_clk),
        .rst   (i_reset),
        .rx    (i_uart_rx),
        .data  (rx_data),
        .valid (rx_valid)
    );

    uart_tx #(.TICK(TICK)) u_tx (
        .clk   (i_clk),
        .rst   (i_reset),
        .start (tx_start),
        .data  (tx_data),
        .tx    (o_uart_tx),
        .ready (tx_ready)
    );

    assign rx_expired  = (idle_cnt == 32'(RX_TIMEOUT - 1));
    assign ack_expired = (ack_cnt == 32'(ACK_TIMEOUT - 1));
    // After a timeout the remaining beats complete at once, with no bus cycle.
    assign beat_end    = timed_out || (o_cs && (i_ack || ack_expired));
    // tx_start is still in flight the cycle after it is raised.
    assign tx_free     = tx_ready && !tx_start;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            o_cs       <= 1'b0;
            o_we       <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_busy     <= 1'b0;
            o_error    <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            is_write   <= 1'b0;
            timed_out  <= 1'b0;
            beats_left <= '0;
            byte_cnt   <= '0;
            ack_cnt    <= '0;
            idle_cnt   <= '0;
            rdata      <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        is_write   <= rx_data[CMD_WRITE_BIT];
                        beats_left <= rx_data[CMD_BEATS_MSB:CMD_BEATS_LSB];
                        byte_cnt   <= '0;
                        idle_cnt   <= '0;
                        timed_out  <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        o_addr   <= (o_addr << 8) | ADDR_WIDTH'(rx_data);
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'(AB - 1)) begin
                            byte_cnt <= '0;
                            state    <= is_write ? S_WDATA : S_BUS;
                        end
                    end else if (rx_expired) begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        o_data   <= (o_data << 8) | DATA_WIDTH'(rx_data);
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'(DB - 1)) begin
                            byte_cnt <= '0;
                            state    <= S_BUS;
                        end
                    end else if (rx_expired) begin
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_BUS: begin
                    if (beat_end) begin
                        o_cs   <= 1'b0;
                        o_we   <= 1'b0;
                        o_addr <= o_addr + 1'b1;
                        rdata  <= (o_cs && i_ack) ? i_data : '0;
                        if (o_cs && !i_ack) begin
                            o_error   <= 1'b1;
                            timed_out <= 1'b1;
                        end
                        if (!is_write) begin
                            byte_cnt <= '0;
                            state    <= S_RSEND;
                        end else if (beats_left == '0) begin
                            state <= S_STATUS;
                        end else begin
                            beats_left <= beats_left - 1'b1;
                            byte_cnt   <= '0;
                            idle_cnt   <= '0;
                            state      <= S_WDATA;
                        end
                    end else if (!o_cs) begin
                        o_cs    <= 1'b1;
                        o_we    <= is_write;
                        ack_cnt <= '0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                S_RSEND: begin
                    if (tx_free) begin
                        tx_data  <= rdata[DATA_WIDTH-1 -: 8];
                        rdata    <= rdata << 8;
                        tx_start <= 1'b1;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'(DB - 1)) begin
                            byte_cnt <= '0;
                            if (beats_left == '0) begin
                                state <= S_STATUS;
                            end else begin
                                beats_left <= beats_left - 1'b1;
                                state      <= S_BUS;
                            end
                        end
                    end
                end
                S_STATUS: begin
                    if (tx_free) begin
                        tx_data  <= timed_out ? STATUS_TIMEOUT : STATUS_OK;
                        tx_start <= 1'b1;
                        o_busy   <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
